// File: rtl/load_store_unit.sv
// load_store_unit -- MEM-stage load/store unit in front of a byte-addressed,
// big-endian, word-wide DataMemory.
//
// Turns LB/LBU/LH/LHU/LW/SB/SH/SW requests into word-aligned memory
// accesses. Byte and half stores are done as read-modify-write (RD then WR).
// Load data is lane-selected and sign/zero-extended. Misaligned, illegal-op
// and out-of-range requests complete straight away with Error=1 and never
// touch memory.
//
// Ports:
//   Clk, Rst_n                     clock, async active-low reset
//   ReqValid/ReqWrite/ReqOp/
//   ReqAddr/ReqWData               request from EX/MEM (ReqOp: 000 B, 001 H,
//                                  010 W, 100 BU, 101 HU)
//   Busy                           pipeline stall (RD/WR states)
//   RespValid/RespData/Error       one-cycle completion, held data/error
//   MemAddress/MemWriteData/
//   MemRead/MemWrite/MemReadData   DataMemory interface (all registered)
//   LoadCount/StoreCount/
//   ErrorCount                     only with LSU_PERF_COUNTERS_EN defined
//
// Build option: `define LSU_PERF_COUNTERS_EN adds the completion counters.

// One big-endian byte lane of the store merge. BE_IDX is the big-endian byte
// number (0 = bits 31:24). The lane takes new data when the store covers it.
module lsu_byte_lane #(
  parameter int BE_IDX = 0
) (
  input  logic [1:0]  size,     // 00 byte, 01 half
  input  logic [1:0]  offset,
  input  logic [15:0] wdata,
  input  logic [7:0]  rd_byte,
  output logic [7:0]  wr_byte
);
  localparam logic [1:0] IDX = 2'(BE_IDX);

  always_comb begin
    wr_byte = rd_byte;
    if (size == 2'b00 && offset == IDX)
      wr_byte = wdata[7:0];
    else if (size == 2'b01 && offset == IDX)
      wr_byte = wdata[15:8];                 // big-endian: MSB at lower address
    else if (size == 2'b01 && offset + 2'd1 == IDX)
      wr_byte = wdata[7:0];
  end
endmodule

module load_store_unit #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        ReqValid,
  input  logic        ReqWrite,
  input  logic [2:0]  ReqOp,
  input  logic [31:0] ReqAddr,
  input  logic [31:0] ReqWData,
  output logic        Busy,
  output logic        RespValid,
  output logic [31:0] RespData,
  output logic        Error,
  output logic [31:0] MemAddress,
  output logic [31:0] MemWriteData,
  output logic        MemRead,
  output logic        MemWrite,
  input  logic [31:0] MemReadData
`ifdef LSU_PERF_COUNTERS_EN
  ,
  output logic [31:0] LoadCount,
  output logic [31:0] StoreCount,
  output logic [31:0] ErrorCount
`endif
);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  // Only the fields still needed after accept are kept; the word address
  // lives in MemAddress.
  typedef struct packed {
    logic        write;
    logic [2:0]  op;
    logic [1:0]  off;
    logic [15:0] wdata;
  } req_t;

  state_t state, state_n;
  req_t   req_q;

  logic accept;
  logic req_err;
  logic [32:0] last_byte;

  assign accept = ReqValid && (state == IDLE || state == DONE);

  // Request legality, evaluated on the live request inputs at accept.
  always_comb begin
    last_byte = {1'b0, ReqAddr[31:2], 2'b00} + 33'd3;
    req_err = 1'b0;
    if (ReqOp == 3'b011 || ReqOp == 3'b110 || ReqOp == 3'b111) req_err = 1'b1;
    if (ReqWrite && ReqOp[2])                                   req_err = 1'b1;
    if (ReqOp[1:0] == 2'b01 && ReqAddr[0])                      req_err = 1'b1;
    if (ReqOp == 3'b010 && ReqAddr[1:0] != 2'b00)               req_err = 1'b1;
    if (last_byte >= 33'(MEM_BYTES))                            req_err = 1'b1;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: begin
        if (DONE == state) state_n = IDLE;
        if (accept) begin
          if (req_err)                state_n = DONE;
          else if (!ReqWrite)         state_n = RD;
          else if (ReqOp == 3'b010)   state_n = WR;
          else                        state_n = RD;   // sub-word store: RMW
        end
      end
      RD:      state_n = req_q.write ? WR : DONE;
      WR:      state_n = DONE;
      default: state_n = IDLE;
    endcase
  end

  // Store merge: memory word as big-endian lanes, one lane instance each.
  logic [NUM_LANES-1:0][7:0] rd_lanes, wr_lanes;
  assign rd_lanes = MemReadData;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lsu_byte_lane #(.BE_IDX(NUM_LANES - 1 - g)) u_lane (
      .size    (req_q.op[1:0]),
      .offset  (req_q.off),
      .wdata   (req_q.wdata),
      .rd_byte (rd_lanes[g]),
      .wr_byte (wr_lanes[g])
    );
  end

  // Load lane select and extension.
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  always_comb begin
    case (req_q.off)
      2'd0:    ld_byte = MemReadData[31:24];
      2'd1:    ld_byte = MemReadData[23:16];
      2'd2:    ld_byte = MemReadData[15:8];
      default: ld_byte = MemReadData[7:0];
    endcase
    ld_half = req_q.off[1] ? MemReadData[15:0] : MemReadData[31:16];
    case (req_q.op)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'h0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'h0, ld_half};
      3'b010:  ld_data = MemReadData;
      default: ld_data = 32'h0;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      req_q        <= '0;
      Busy         <= 1'b0;
      RespValid    <= 1'b0;
      RespData     <= 32'h0;
      Error        <= 1'b0;
      MemAddress   <= 32'h0;
      MemWriteData <= 32'h0;
      MemRead      <= 1'b0;
      MemWrite     <= 1'b0;
    end else begin
      state     <= state_n;
      // Memory strobes are decoded from the next state so each RD/WR cycle
      // gets exactly one registered pulse, and RD->DONE->RD leaves a gap.
      MemRead   <= (state_n == RD);
      MemWrite  <= (state_n == WR);
      Busy      <= (state_n == RD) || (state_n == WR);
      RespValid <= (state_n == DONE);

      if (accept) begin
        req_q <= '{write: ReqWrite, op: ReqOp, off: ReqAddr[1:0],
                   wdata: ReqWData[15:0]};
        if (req_err) begin
          Error    <= 1'b1;
          RespData <= 32'h0;
        end else begin
          MemAddress <= {ReqAddr[31:2], 2'b00};
          if (ReqWrite && ReqOp == 3'b010) MemWriteData <= ReqWData;
        end
      end

      // Leaving RD: either finish the load or stage the merged store word.
      if (state == RD) begin
        if (req_q.write) MemWriteData <= wr_lanes;
        else begin
          RespData <= ld_data;
          Error    <= 1'b0;
        end
      end

      if (state == WR) begin
        RespData <= 32'h0;
        Error    <= 1'b0;
      end
    end
  end

`ifdef LSU_PERF_COUNTERS_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      LoadCount  <= 32'h0;
      StoreCount <= 32'h0;
      ErrorCount <= 32'h0;
    end else begin
      if (accept && req_err)           ErrorCount <= ErrorCount + 32'd1;
      if (state == RD && !req_q.write) LoadCount  <= LoadCount + 32'd1;
      if (state == WR)                 StoreCount <= StoreCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases followed by a
// randomized stream checked against an arithmetic reference model.
module tb_load_store_unit;
  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        ReqValid = 1'b0, ReqWrite = 1'b0;
  logic [2:0]  ReqOp = 3'd0;
  logic [31:0] ReqAddr = 32'h0, ReqWData = 32'h0;
  logic        Busy, RespValid, Error, MemRead, MemWrite;
  logic [31:0] RespData, MemAddress, MemWriteData, MemReadData;
`ifdef LSU_PERF_COUNTERS_EN
  logic [31:0] LoadCount, StoreCount, ErrorCount;
`endif

  always #5 Clk = ~Clk;

  load_store_unit #(.MEM_BYTES(65536)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .ReqValid(ReqValid), .ReqWrite(ReqWrite),
    .ReqOp(ReqOp), .ReqAddr(ReqAddr), .ReqWData(ReqWData), .Busy(Busy),
    .RespValid(RespValid), .RespData(RespData), .Error(Error),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemReadData(MemReadData)
`ifdef LSU_PERF_COUNTERS_EN
    , .LoadCount(LoadCount), .StoreCount(StoreCount), .ErrorCount(ErrorCount)
`endif
  );

  // DataMemory: 256 words, address bits above 9 alias.
  logic [31:0] dmem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        tb_we = 1'b0;
  logic [7:0]  tb_a = 8'd0;
  logic [31:0] tb_d = 32'h0;

  always @(posedge Clk)
    if (MemWrite) dmem[MemAddress[9:2]] <= MemWriteData;
    else if (tb_we) dmem[tb_a] <= tb_d;

  assign MemReadData = dmem[MemAddress[9:2]];

  int tests = 0, fails = 0;
  int n_ld = 0, n_st = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory strobes must never overlap and addresses must stay word-aligned.
  always @(negedge Clk) if (Rst_n) begin
    tests++;
    assert (!(MemRead && MemWrite) && MemAddress[1:0] == 2'b00) else begin
      fails++;
      $error("FAIL protocol: rd=%b wr=%b addr=%h", MemRead, MemWrite, MemAddress);
    end
  end

  task automatic poke(input int idx, input logic [31:0] d);
    tb_we = 1'b1; tb_a = 8'(idx); tb_d = d;
    @(posedge Clk); #1 tb_we = 1'b0;
    ref_mem[idx] = d;
  endtask

  // Issues one request (the caller sits #1 after a posedge, possibly in DONE)
  // and checks timing, strobes, response and memory against the model.
  task automatic do_req(input logic w, input logic [2:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input bit noise,
                        output logic [31:0] got_d, output logic got_e);
    int idx, o, sh, lat, nrd, nwr, nbusy;
    int exp_lat, exp_rd, exp_wr;
    logic [31:0] old, exp_d, neww, b, h;
    longint last;
    bit err;
    idx  = int'((addr >> 2) & 32'd255);
    o    = int'(addr & 32'd3);
    old  = ref_mem[idx];
    last = longint'(addr & 32'hFFFF_FFFC) + 3;
    err  = (op == 3'd3 || op == 3'd6 || op == 3'd7) || (w && op >= 3'd4) ||
           (op[1:0] == 2'd1 && (o % 2) != 0) || (op == 3'd2 && o != 0) ||
           (last >= 65536);
    exp_d = 32'h0;
    neww  = old;
    if (!err && !w) begin
      b = (old >> (8 * (3 - o))) & 32'hFF;
      h = (old >> (8 * (2 - o))) & 32'hFFFF;
      case (op)
        3'd0: exp_d = (b >= 32'h80) ? b - 32'h100 : b;
        3'd4: exp_d = b;
        3'd1: exp_d = (h >= 32'h8000) ? h - 32'h10000 : h;
        3'd5: exp_d = h;
        default: exp_d = old;
      endcase
    end
    if (!err && w) begin
      if (op == 3'd2) neww = wd;
      else if (op == 3'd0) begin
        sh = 8 * (3 - o);
        neww = (old & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else begin
        sh = 8 * (2 - o);
        neww = (old & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
    end
    exp_lat = err ? 1 : (w && op != 3'd2) ? 3 : 2;
    exp_rd  = (err || (w && op == 3'd2)) ? 0 : 1;
    exp_wr  = (!err && w) ? 1 : 0;

    ReqValid = 1'b1; ReqWrite = w; ReqOp = op; ReqAddr = addr; ReqWData = wd;
    @(posedge Clk); #1 ReqValid = 1'b0;
    lat = 1; nrd = 0; nwr = 0; nbusy = 0;
    while (!RespValid && lat < 8) begin
      nrd += int'(MemRead); nwr += int'(MemWrite); nbusy += int'(Busy);
      if (noise && Busy) begin
        ReqValid = 1'b1; ReqWrite = 1'($urandom); ReqOp = 3'($urandom);
        ReqAddr = $urandom; ReqWData = $urandom;
      end
      @(posedge Clk); #1 ReqValid = 1'b0;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("reads",   32'(nrd), 32'(exp_rd));
    check("writes",  32'(nwr), 32'(exp_wr));
    check("busy",    32'(nbusy), 32'(exp_rd + exp_wr));
    check("rdata",   RespData, exp_d);
    check("error",   32'(Error), 32'(err));
    if (!err) check("memaddr", MemAddress, addr & 32'hFFFF_FFFC);
    ref_mem[idx] = neww;
    check("memword", dmem[idx], ref_mem[idx]);
    if (err) n_err++; else if (w) n_st++; else n_ld++;
    got_d = RespData; got_e = Error;
  endtask

  initial begin
    logic [31:0] d;
    logic e, seen;
    // Reset state and memory preload (memory writes only happen on Clk).
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    poke(32'h40, 32'h8899AABB);
    check("rst_busy", 32'(Busy), 32'h0);
    check("rst_rv",   32'(RespValid), 32'h0);
    check("rst_data", RespData, 32'h0);
    check("rst_err",  32'(Error), 32'h0);
    check("rst_addr", MemAddress, 32'h0);
    check("rst_wd",   MemWriteData, 32'h0);
    check("rst_rw",   {30'h0, MemRead, MemWrite}, 32'h0);
    @(negedge Clk) Rst_n = 1'b1;
    @(posedge Clk); #1;

    // Big-endian lane selection on 0x8899AABB at 0x100.
    do_req(1'b0, 3'b000, 32'h101, 32'h0, 1'b0, d, e); check("lb_101",  d, 32'hFFFFFF99);
    do_req(1'b0, 3'b101, 32'h102, 32'h0, 1'b0, d, e); check("lhu_102", d, 32'h0000AABB);
    do_req(1'b0, 3'b001, 32'h100, 32'h0, 1'b0, d, e); check("lh_100",  d, 32'hFFFF8899);
    do_req(1'b0, 3'b100, 32'h100, 32'h0, 1'b0, d, e); check("lbu_100", d, 32'h00000088);
    do_req(1'b1, 3'b000, 32'h103, 32'hCC, 1'b0, d, e); check("sb_103", dmem[8'h40], 32'h8899AACC);
    do_req(1'b1, 3'b001, 32'h100, 32'h1234, 1'b1, d, e); check("sh_100", dmem[8'h40], 32'h1234AACC);

    // Error cases: misaligned, illegal op, unsigned store, out of range.
    do_req(1'b0, 3'b010, 32'h102, 32'h0, 1'b0, d, e); check("lw_mis", 32'(e), 32'h1);
    do_req(1'b1, 3'b001, 32'h101, 32'h55, 1'b0, d, e); check("sh_mis", 32'(e), 32'h1);
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 1'b0, d, e); check("op011", 32'(e), 32'h1);
    do_req(1'b1, 3'b100, 32'h100, 32'h0, 1'b0, d, e); check("sbu",   32'(e), 32'h1);
    // Word 0xFFFC spans bytes 0xFFFC..0xFFFF, the last legal word.
    do_req(1'b0, 3'b010, 32'hFFFC, 32'h0, 1'b0, d, e); check("lw_fffc", 32'(e), 32'h0);
    do_req(1'b0, 3'b010, 32'h10000, 32'h0, 1'b0, d, e); check("lw_10000", 32'(e), 32'h1);

    // Back-to-back: second request presented while the first is in DONE.
    do_req(1'b1, 3'b010, 32'h200, 32'h12345678, 1'b0, d, e);
    do_req(1'b0, 3'b010, 32'h200, 32'h0, 1'b0, d, e); check("b2b_lw", d, 32'h12345678);

    // Reset during the WR cycle of an SH.
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqOp = 3'b001; ReqAddr = 32'h80; ReqWData = 32'hBEEF;
    @(posedge Clk); #1 ReqValid = 1'b0;
    @(posedge Clk); #1 check("midrst_wr", 32'(MemWrite), 32'h1);
    #2 Rst_n = 1'b0;
    #1 check("midrst_out", {Busy, RespValid, Error, MemRead, MemWrite}, 32'h0);
    check("midrst_data", RespData | MemAddress | MemWriteData, 32'h0);
    @(posedge Clk); #1 check("midrst_mem", dmem[8'h20], ref_mem[8'h20]);
    @(negedge Clk) Rst_n = 1'b1;
    seen = 1'b0;
    repeat (3) begin @(posedge Clk); #1 seen |= RespValid; end
    check("midrst_norv", 32'(seen), 32'h0);
    n_ld = 0; n_st = 0; n_err = 0;

    // Randomized stream with idle gaps and ignored requests while busy.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 9) == 0) ? 32'h10000 + $urandom_range(0, 255)
                                      : 32'($urandom_range(0, 1023));
      repeat ($urandom_range(0, 2)) begin @(posedge Clk); #1; end
      do_req(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom,
             1'($urandom), d, e);
    end

    @(posedge Clk); #1 check("idle_rv", 32'(RespValid), 32'h0);
`ifdef LSU_PERF_COUNTERS_EN
    check("cnt_ld",  LoadCount,  32'(n_ld));
    check("cnt_st",  StoreCount, 32'(n_st));
    check("cnt_err", ErrorCount, 32'(n_err));
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
